// File: rtl/pipeline_pkg.sv
// Shared types and constants for the MEM-stage access unit and its MEM/WB register bank.
package pipeline_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        WB_HOLD   = 2'd0,
        WB_LOAD   = 2'd1,
        WB_BUBBLE = 2'd2
    } wb_op_e;

    localparam int REG_ADDR_W = 5;
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic jump_link;
    } wb_ctrl_t;

    localparam wb_ctrl_t WB_BUBBLE_CTRL = '0;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return |(addr_lsb & WORD_ALIGN_MASK);
    endfunction

endpackage

// File: rtl/mem_wb_capture.sv
// MEM/WB register bank: load, load-bubble or hold, selected by the access FSM.
module mem_wb_capture
    import pipeline_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  wb_op_e                wb_op,
    input  logic                  load_rdata,
    input  logic                  fault_in,
    input  wb_ctrl_t              ctrl_in,
    input  logic [DATA_W-1:0]     alu_in,
    input  logic [DATA_W-1:0]     pc_in,
    input  logic [DATA_W-1:0]     rdata_in,
    input  logic [REG_ADDR_W-1:0] wreg_in,
    output wb_ctrl_t              ctrl_out,
    output logic [DATA_W-1:0]     alu_out,
    output logic [DATA_W-1:0]     pc_out,
    output logic [DATA_W-1:0]     rdata_out,
    output logic [REG_ADDR_W-1:0] wreg_out,
    output logic                  fault_out
);

    wb_ctrl_t              ctrl_q, ctrl_d;
    logic [DATA_W-1:0]     alu_q, alu_d;
    logic [DATA_W-1:0]     pc_q, pc_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic [REG_ADDR_W-1:0] wreg_q, wreg_d;
    logic                  fault_q, fault_d;

    // A bubble only kills the controls; data fields keep their last values.
    always_comb begin
        ctrl_d  = ctrl_q;
        alu_d   = alu_q;
        pc_d    = pc_q;
        rdata_d = rdata_q;
        wreg_d  = wreg_q;
        fault_d = fault_in;
        case (wb_op)
            WB_LOAD: begin
                ctrl_d = ctrl_in;
                alu_d  = alu_in;
                pc_d   = pc_in;
                wreg_d = wreg_in;
                if (load_rdata) begin
                    rdata_d = rdata_in;
                end
            end
            WB_BUBBLE: begin
                ctrl_d = WB_BUBBLE_CTRL;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= '0;
            alu_q   <= '0;
            pc_q    <= '0;
            rdata_q <= '0;
            wreg_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            alu_q   <= alu_d;
            pc_q    <= pc_d;
            rdata_q <= rdata_d;
            wreg_q  <= wreg_d;
            fault_q <= fault_d;
        end
    end

    assign ctrl_out  = ctrl_q;
    assign alu_out   = alu_q;
    assign pc_out    = pc_q;
    assign rdata_out = rdata_q;
    assign wreg_out  = wreg_q;
    assign fault_out = fault_q;

endmodule

// File: rtl/mem_stage_access_unit.sv
// MEM stage: word loads/stores over a req/ready bus, pipeline stall, MEM/WB capture,
// misalignment and bus-timeout faults.
//
// state | meaning
// IDLE  | evaluate the EX/MEM instruction; start a bus access if aligned
// BUSY  | request outstanding; wait for dmem_ready or the timeout count
module mem_stage_access_unit
    import pipeline_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  RegWriteM,
    input  logic                  MemtoRegM,
    input  logic                  MemWriteM,
    input  logic                  JumpLinkM,
    input  logic [DATA_W-1:0]     ALUOutM,
    input  logic [DATA_W-1:0]     WriteDataM,
    input  logic [REG_ADDR_W-1:0] WriteRegM,
    input  logic [DATA_W-1:0]     PCPlus4M,
    output logic                  StallM,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_W-1:0]     dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic                  dmem_ready,
    input  logic [DATA_W-1:0]     dmem_rdata,
    output logic                  RegWriteW,
    output logic                  MemtoRegW,
    output logic                  JumpLinkW,
    output logic [DATA_W-1:0]     ReadDataW,
    output logic [DATA_W-1:0]     ALUOutW,
    output logic [DATA_W-1:0]     PCPlus4W,
    output logic [REG_ADDR_W-1:0] WriteRegW,
    output logic                  MemFaultW
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic     access;
    logic     misaligned;
    wb_op_e   wb_op;
    logic     load_rdata;
    logic     fault;
    wb_ctrl_t ctrl_m, ctrl_w;

    assign access     = MemtoRegM | MemWriteM;
    assign misaligned = is_misaligned(ALUOutM[1:0]);
    assign ctrl_m     = '{reg_write: RegWriteM, mem_to_reg: MemtoRegM, jump_link: JumpLinkM};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        StallM     = 1'b0;
        wb_op      = WB_HOLD;
        load_rdata = 1'b0;
        fault      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!access) begin
                    wb_op = WB_LOAD;
                end else if (misaligned) begin
                    wb_op = WB_BUBBLE;
                    fault = 1'b1;
                end else begin
                    StallM  = 1'b1;
                    wb_op   = WB_BUBBLE;
                    req_d   = 1'b1;
                    we_d    = MemWriteM;
                    addr_d  = ALUOutM;
                    wdata_d = WriteDataM;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Ready takes priority over the timeout in the final count cycle.
                if (dmem_ready) begin
                    wb_op      = WB_LOAD;
                    load_rdata = MemtoRegM;
                    req_d      = 1'b0;
                    state_d    = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    wb_op   = WB_BUBBLE;
                    fault   = 1'b1;
                    req_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    StallM = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;

    mem_wb_capture #(
        .DATA_W(DATA_W)
    ) u_mem_wb_capture (
        .clk       (CLK),
        .rst_n     (RST_N),
        .wb_op     (wb_op),
        .load_rdata(load_rdata),
        .fault_in  (fault),
        .ctrl_in   (ctrl_m),
        .alu_in    (ALUOutM),
        .pc_in     (PCPlus4M),
        .rdata_in  (dmem_rdata),
        .wreg_in   (WriteRegM),
        .ctrl_out  (ctrl_w),
        .alu_out   (ALUOutW),
        .pc_out    (PCPlus4W),
        .rdata_out (ReadDataW),
        .wreg_out  (WriteRegW),
        .fault_out (MemFaultW)
    );

    assign RegWriteW = ctrl_w.reg_write;
    assign MemtoRegW = ctrl_w.mem_to_reg;
    assign JumpLinkW = ctrl_w.jump_link;

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Scoreboard bench for mem_stage_access_unit with a short bus timeout.
module tb_mem_stage_access_unit;

    localparam int DW = 32;
    localparam int TO = 4;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          RegWriteM, MemtoRegM, MemWriteM, JumpLinkM;
    logic [DW-1:0] ALUOutM, WriteDataM, PCPlus4M;
    logic [4:0]    WriteRegM;
    logic          StallM;
    logic          dmem_req, dmem_we;
    logic [DW-1:0] dmem_addr, dmem_wdata;
    logic          dmem_ready;
    logic [DW-1:0] dmem_rdata;
    logic          RegWriteW, MemtoRegW, JumpLinkW;
    logic [DW-1:0] ReadDataW, ALUOutW, PCPlus4W;
    logic [4:0]    WriteRegW;
    logic          MemFaultW;

    always #5 CLK = ~CLK;

    mem_stage_access_unit #(
        .DATA_W(DW), .TIMEOUT_CYCLES(TO), .CNT_W(8)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .JumpLinkM(JumpLinkM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
        .WriteRegM(WriteRegM), .PCPlus4M(PCPlus4M), .StallM(StallM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .JumpLinkW(JumpLinkW),
        .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .PCPlus4W(PCPlus4W),
        .WriteRegW(WriteRegW), .MemFaultW(MemFaultW)
    );

    typedef struct {
        logic          rw, m2r, jl, fault;
        logic [DW-1:0] alu, rd, pc;
        logic [4:0]    wr;
    } wb_exp_t;

    wb_exp_t sb[$];
    int errors = 0;
    int checks = 0;

    logic [DW-1:0] m_alu = '0, m_rd = '0, m_pc = '0;
    logic [4:0]    m_wr = '0;

    int            rdy_wait;
    logic [DW-1:0] rdy_data;
    int            stall_cyc, req_cyc, we_cyc;
    logic          first_req;
    logic [DW-1:0] addr_seen, wdata_seen;

    // Drives one EX/MEM instruction and pushes the MEM/WB result the bus behaviour implies.
    task automatic issue(input logic rw, m2r, mw, jl, input logic [DW-1:0] alu, wd,
                         input logic [4:0] wr, input logic [DW-1:0] pc,
                         input int wait_cyc, input logic [DW-1:0] rdata);
        wb_exp_t e;
        RegWriteM = rw; MemtoRegM = m2r; MemWriteM = mw; JumpLinkM = jl;
        ALUOutM = alu; WriteDataM = wd; WriteRegM = wr; PCPlus4M = pc;
        rdy_wait = wait_cyc; rdy_data = rdata;
        if ((m2r | mw) && (alu[1:0] != 2'b00 || wait_cyc < 0 || wait_cyc > TO - 1)) begin
            e.rw = 1'b0; e.m2r = 1'b0; e.jl = 1'b0; e.fault = 1'b1;
        end else begin
            m_alu = alu; m_pc = pc; m_wr = wr;
            if (m2r) m_rd = rdata;
            e.rw = rw; e.m2r = m2r; e.jl = jl; e.fault = 1'b0;
        end
        e.alu = m_alu; e.rd = m_rd; e.pc = m_pc; e.wr = m_wr;
        sb.push_back(e);
    endtask

    // Acts as the memory: ready after rdy_wait request cycles (never if negative).
    task automatic exec();
        bit pending = 1;
        bit done;
        stall_cyc = 0; req_cyc = 0; we_cyc = 0; first_req = 1'bx;
        for (int c = 0; c < 40 && pending; c++) begin
            @(negedge CLK);
            if (c == 0) first_req = dmem_req;
            if (dmem_req) begin
                req_cyc++;
                addr_seen = dmem_addr; wdata_seen = dmem_wdata;
                if (dmem_we) we_cyc++;
                dmem_ready = (rdy_wait >= 0) && (req_cyc > rdy_wait);
                dmem_rdata = dmem_ready ? rdy_data : 32'hBAD0_BAD0;
            end else begin
                dmem_ready = 1'b0;
            end
            #1;
            done = !StallM;
            if (StallM) stall_cyc++;
            @(posedge CLK); #1;
            dmem_ready = 1'b0;
            if (done) pending = 0;
        end
        checks++;
        if (pending) begin
            errors++;
            $display("FAIL exec_bound: StallM still high after 40 cycles, required low");
        end
    endtask

    task automatic test_reset();
        checks += 6;
        if (dmem_req !== 1'b0)  begin errors++; $display("FAIL rst_req: got %b req 0", dmem_req); end
        if (RegWriteW !== 1'b0) begin errors++; $display("FAIL rst_rw: got %b req 0", RegWriteW); end
        if (ALUOutW !== '0)     begin errors++; $display("FAIL rst_alu: got %h req 0", ALUOutW); end
        if (ReadDataW !== '0)   begin errors++; $display("FAIL rst_rd: got %h req 0", ReadDataW); end
        if (MemFaultW !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b req 0", MemFaultW); end
        if (StallM !== 1'b0)    begin errors++; $display("FAIL rst_stall: got %b req 0", StallM); end
    endtask

    task automatic test_alu();
        wb_exp_t e;
        issue(1, 0, 0, 0, 32'h10, 32'h0, 5'd5, 32'h4, 0, 32'h0);
        exec();
        e = sb.pop_front();
        checks += 6;
        if (stall_cyc != 0)     begin errors++; $display("FAIL alu_stall: got %0d req 0", stall_cyc); end
        if (req_cyc != 0)       begin errors++; $display("FAIL alu_req: got %0d req 0", req_cyc); end
        if (RegWriteW !== e.rw) begin errors++; $display("FAIL alu_rw: got %b req %b", RegWriteW, e.rw); end
        if (ALUOutW !== e.alu)  begin errors++; $display("FAIL alu_out: got %h req %h", ALUOutW, e.alu); end
        if (WriteRegW !== e.wr) begin errors++; $display("FAIL alu_wr: got %0d req %0d", WriteRegW, e.wr); end
        if (MemFaultW !== e.fault) begin errors++; $display("FAIL alu_fault: got %b req %b", MemFaultW, e.fault); end
    endtask

    task automatic test_jal();
        wb_exp_t e;
        issue(1, 0, 0, 1, 32'h20, 32'h0, 5'd31, 32'h48, 0, 32'h0);
        exec();
        e = sb.pop_front();
        checks += 3;
        if (JumpLinkW !== e.jl) begin errors++; $display("FAIL jal_jl: got %b req %b", JumpLinkW, e.jl); end
        if (PCPlus4W !== e.pc)  begin errors++; $display("FAIL jal_pc: got %h req %h", PCPlus4W, e.pc); end
        if (WriteRegW !== e.wr) begin errors++; $display("FAIL jal_wr: got %0d req %0d", WriteRegW, e.wr); end
    endtask

    // Three wait cycles makes ready land in the last count cycle: ready must win.
    task automatic test_load();
        wb_exp_t e;
        issue(1, 1, 0, 0, 32'h100, 32'h0, 5'd7, 32'h50, 3, 32'hDEAD_BEEF);
        exec();
        e = sb.pop_front();
        checks += 8;
        if (req_cyc != 4)        begin errors++; $display("FAIL ld_req: got %0d req 4", req_cyc); end
        if (stall_cyc != 4)      begin errors++; $display("FAIL ld_stall: got %0d req 4", stall_cyc); end
        if (addr_seen !== 32'h100) begin errors++; $display("FAIL ld_addr: got %h req 100", addr_seen); end
        if (we_cyc != 0)         begin errors++; $display("FAIL ld_we: got %0d req 0", we_cyc); end
        if (ReadDataW !== e.rd)  begin errors++; $display("FAIL ld_rd: got %h req %h", ReadDataW, e.rd); end
        if (MemtoRegW !== e.m2r) begin errors++; $display("FAIL ld_m2r: got %b req %b", MemtoRegW, e.m2r); end
        if (MemFaultW !== e.fault) begin errors++; $display("FAIL ld_fault: got %b req %b", MemFaultW, e.fault); end
        if (dmem_req !== 1'b0)   begin errors++; $display("FAIL ld_req_drop: got %b req 0", dmem_req); end
    endtask

    task automatic test_store();
        wb_exp_t e;
        issue(0, 0, 1, 0, 32'h204, 32'h1234_5678, 5'd0, 32'h54, 0, 32'h0);
        exec();
        e = sb.pop_front();
        checks += 6;
        if (we_cyc != 1)        begin errors++; $display("FAIL st_we: got %0d req 1", we_cyc); end
        if (req_cyc != 1)       begin errors++; $display("FAIL st_req: got %0d req 1", req_cyc); end
        if (wdata_seen !== 32'h1234_5678) begin errors++; $display("FAIL st_wdata: got %h req 12345678", wdata_seen); end
        if (stall_cyc != 1)     begin errors++; $display("FAIL st_stall: got %0d req 1", stall_cyc); end
        if (ReadDataW !== e.rd) begin errors++; $display("FAIL st_rd: got %h req %h", ReadDataW, e.rd); end
        if (RegWriteW !== e.rw) begin errors++; $display("FAIL st_rw: got %b req %b", RegWriteW, e.rw); end
    endtask

    task automatic test_misaligned();
        wb_exp_t e;
        issue(1, 1, 0, 0, 32'h102, 32'h0, 5'd9, 32'h58, 0, 32'h5555_5555);
        exec();
        e = sb.pop_front();
        checks += 5;
        if (req_cyc != 0)       begin errors++; $display("FAIL mis_req: got %0d req 0", req_cyc); end
        if (stall_cyc != 0)     begin errors++; $display("FAIL mis_stall: got %0d req 0", stall_cyc); end
        if (MemFaultW !== e.fault) begin errors++; $display("FAIL mis_fault: got %b req %b", MemFaultW, e.fault); end
        if (RegWriteW !== e.rw) begin errors++; $display("FAIL mis_rw: got %b req %b", RegWriteW, e.rw); end
        if (ReadDataW !== e.rd) begin errors++; $display("FAIL mis_rd: got %h req %h", ReadDataW, e.rd); end
        issue(1, 0, 0, 0, 32'h8, 32'h0, 5'd2, 32'h5C, 0, 32'h0);
        exec();
        e = sb.pop_front();
        checks += 2;
        if (MemFaultW !== e.fault) begin errors++; $display("FAIL mis_pulse: got %b req %b", MemFaultW, e.fault); end
        if (ALUOutW !== e.alu)  begin errors++; $display("FAIL mis_next_alu: got %h req %h", ALUOutW, e.alu); end
    endtask

    task automatic test_timeout();
        wb_exp_t e;
        issue(1, 1, 0, 0, 32'h400, 32'h0, 5'd11, 32'h60, -1, 32'h0);
        exec();
        e = sb.pop_front();
        checks += 5;
        if (req_cyc != TO)      begin errors++; $display("FAIL to_req: got %0d req %0d", req_cyc, TO); end
        if (stall_cyc != TO)    begin errors++; $display("FAIL to_stall: got %0d req %0d", stall_cyc, TO); end
        if (MemFaultW !== e.fault) begin errors++; $display("FAIL to_fault: got %b req %b", MemFaultW, e.fault); end
        if (RegWriteW !== e.rw) begin errors++; $display("FAIL to_rw: got %b req %b", RegWriteW, e.rw); end
        if (dmem_req !== 1'b0)  begin errors++; $display("FAIL to_req_drop: got %b req 0", dmem_req); end
        issue(1, 0, 0, 0, 32'h14, 32'h0, 5'd3, 32'h64, 0, 32'h0);
        exec();
        e = sb.pop_front();
        checks += 3;
        if (stall_cyc != 0)     begin errors++; $display("FAIL to_idle_stall: got %0d req 0", stall_cyc); end
        if (MemFaultW !== e.fault) begin errors++; $display("FAIL to_pulse: got %b req %b", MemFaultW, e.fault); end
        if (RegWriteW !== e.rw) begin errors++; $display("FAIL to_next_rw: got %b req %b", RegWriteW, e.rw); end
    endtask

    task automatic test_back_to_back();
        wb_exp_t e;
        issue(1, 1, 0, 0, 32'h500, 32'h0, 5'd12, 32'h68, 0, 32'hCAFE_0001);
        exec();
        e = sb.pop_front();
        checks++;
        if (ReadDataW !== e.rd) begin errors++; $display("FAIL b2b_rd0: got %h req %h", ReadDataW, e.rd); end
        issue(1, 1, 0, 0, 32'h504, 32'h0, 5'd13, 32'h6C, 1, 32'hCAFE_0002);
        exec();
        e = sb.pop_front();
        checks += 5;
        if (first_req !== 1'b0) begin errors++; $display("FAIL b2b_gap: got %b req 0", first_req); end
        if (req_cyc != 2)       begin errors++; $display("FAIL b2b_req: got %0d req 2", req_cyc); end
        if (addr_seen !== 32'h504) begin errors++; $display("FAIL b2b_addr: got %h req 504", addr_seen); end
        if (ReadDataW !== e.rd) begin errors++; $display("FAIL b2b_rd1: got %h req %h", ReadDataW, e.rd); end
        if (WriteRegW !== e.wr) begin errors++; $display("FAIL b2b_wr: got %0d req %0d", WriteRegW, e.wr); end
    endtask

    task automatic test_reset_mid_busy();
        wb_exp_t e;
        RegWriteM = 1; MemtoRegM = 1; MemWriteM = 0; JumpLinkM = 1;
        ALUOutM = 32'h300; WriteDataM = 32'h0; WriteRegM = 5'd14; PCPlus4M = 32'h70;
        dmem_ready = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        checks++;
        if (dmem_req !== 1'b1) begin errors++; $display("FAIL rmb_busy: got %b req 1", dmem_req); end
        #2 RST_N = 1'b0;
        #1;
        checks += 6;
        if (dmem_req !== 1'b0)  begin errors++; $display("FAIL rmb_req: got %b req 0", dmem_req); end
        if (RegWriteW !== 1'b0) begin errors++; $display("FAIL rmb_rw: got %b req 0", RegWriteW); end
        if (ALUOutW !== '0)     begin errors++; $display("FAIL rmb_alu: got %h req 0", ALUOutW); end
        if (ReadDataW !== '0)   begin errors++; $display("FAIL rmb_rd: got %h req 0", ReadDataW); end
        if (PCPlus4W !== '0)    begin errors++; $display("FAIL rmb_pc: got %h req 0", PCPlus4W); end
        if (WriteRegW !== '0)   begin errors++; $display("FAIL rmb_wr: got %0d req 0", WriteRegW); end
        m_alu = '0; m_rd = '0; m_pc = '0; m_wr = '0;
        sb.delete();
        @(posedge CLK); #1 RST_N = 1'b1;
        issue(1, 0, 0, 0, 32'h7C, 32'h0, 5'd15, 32'h74, 0, 32'h0);
        exec();
        e = sb.pop_front();
        checks += 4;
        if (stall_cyc != 0)     begin errors++; $display("FAIL rmb_nop_stall: got %0d req 0", stall_cyc); end
        if (req_cyc != 0)       begin errors++; $display("FAIL rmb_nop_req: got %0d req 0", req_cyc); end
        if (RegWriteW !== e.rw) begin errors++; $display("FAIL rmb_nop_rw: got %b req %b", RegWriteW, e.rw); end
        if (ALUOutW !== e.alu)  begin errors++; $display("FAIL rmb_nop_alu: got %h req %h", ALUOutW, e.alu); end
    endtask

    initial begin
        RST_N = 1'b0;
        RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0; JumpLinkM = 0;
        ALUOutM = '0; WriteDataM = '0; WriteRegM = '0; PCPlus4M = '0;
        dmem_ready = 1'b0; dmem_rdata = '0;
        rdy_wait = 0; rdy_data = '0;
        #12;
        test_reset();
        @(posedge CLK); #1 RST_N = 1'b1;
        test_alu();
        test_jal();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage_access_unit.md
Name: mem_stage_access_unit

Overview:
MEM-stage consumer of the EX/MEM pipeline register outputs. It drives word loads and stores onto a wait-stated data-memory bus using a req/ready handshake. It stalls the upstream pipeline while an access is outstanding, and registers the results into the MEM/WB boundary for the writeback stage. It also detects misaligned accesses and bus timeouts and reports them as a one-cycle fault.

Parameters:
DATA_W, 32, data and address width.
TIMEOUT_CYCLES, 255, maximum BUSY cycles before an access is aborted. Legal range 1..2^CNT_W-1.
CNT_W, 8, width of the timeout counter.

Ports:
CLK  in  1  clock, rising edge.
RST_N  in  1  reset, asynchronous, active-low.
RegWriteM  in  1  register-write control from EX/MEM.
MemtoRegM  in  1  load request (word).
MemWriteM  in  1  store request (word).
JumpLinkM  in  1  jump-and-link marker.
ALUOutM  in  DATA_W  effective address or ALU result.
WriteDataM  in  DATA_W  store data.
WriteRegM  in  5  destination register.
PCPlus4M  in  DATA_W  link value.
StallM  out  1  freeze EX/MEM and all earlier stages; combinational.
dmem_req  out  1  bus request; registered.
dmem_we  out  1  1 = store; registered.
dmem_addr  out  DATA_W  word-aligned address; registered.
dmem_wdata  out  DATA_W  store data; registered.
dmem_ready  in  1  bus completion; sampled only while dmem_req=1.
dmem_rdata  in  DATA_W  load data; valid when dmem_ready=1.
RegWriteW, MemtoRegW, JumpLinkW  out  1 each  registered MEM/WB controls.
ReadDataW, ALUOutW, PCPlus4W  out  DATA_W  registered MEM/WB data.
WriteRegW  out  5  registered destination register.
MemFaultW  out  1  one-cycle fault pulse, aligned with a bubble.

Behaviour:
- Reset (RST_N=0, async): FSM=IDLE, counter=0. All registered outputs are 0, including dmem_req and MemFaultW. Outputs stay at these values until the first CLK edge after reset release.
- Define access = MemtoRegM | MemWriteM. Define misaligned = ALUOutM[1:0] != 0.
- FSM states: IDLE, BUSY.
- IDLE, access=0: StallM=0. At the edge, MEM/WB registers load the *M inputs, ReadDataW holds its value, MemFaultW=0.
- IDLE, access=1, misaligned=1: no bus request and StallM=0. MEM/WB loads a bubble (RegWriteW=0, MemtoRegW=0, JumpLinkW=0) and MemFaultW=1 for one cycle.
- IDLE, access=1, aligned: StallM=1.
  - Load dmem_addr=ALUOutM, dmem_wdata=WriteDataM, dmem_we=MemWriteM, dmem_req=1.
  - Clear the counter and go to BUSY.
  - MEM/WB loads a bubble.
- BUSY: dmem_req, we, addr and wdata are held stable until completion. StallM = ~dmem_ready. Upstream is frozen, so the *M inputs are stable.
  - dmem_ready=1: MEM/WB loads the *M inputs and ReadDataW=dmem_rdata (loads only; stores leave ReadDataW unchanged). dmem_req drops to 0 at the same edge and the FSM returns to IDLE. Because StallM=0, EX/MEM advances at that same edge.
  - dmem_ready=0: counter increments. When counter == TIMEOUT_CYCLES-1 and ready is still 0: abort, dmem_req drops to 0, MEM/WB loads a bubble, MemFaultW=1, StallM=0 that cycle, FSM returns to IDLE.
  - Ready arriving in the timeout cycle: ready wins and no fault is raised.
- Latency: a zero-wait memory access occupies 2 cycles (1 stall cycle). Each additional dmem_ready=0 cycle adds one stall cycle. Non-memory instructions take 1 cycle.
- Back-to-back accesses: the IDLE cycle after completion evaluates the next instruction's access. The bus sees dmem_req low for at least one cycle between requests.
- dmem_ready while dmem_req=0: ignored.
- Reset mid-BUSY: dmem_req drops asynchronously and the in-flight access is discarded. The bus must tolerate an abandoned request.
- Address and data arithmetic: pass-through only; no byte or halfword support. Counter width is CNT_W bits and never wraps, because it stops at TIMEOUT_CYCLES-1.

Decomposition:
- Shared package (pipeline_pkg): state enum {IDLE, BUSY}, REG_ADDR_W=5, WORD_ALIGN_MASK=2'b11, and a MEM/WB bubble constant.
- One natural sub-module: mem_wb_capture, the MEM/WB register bank with load / load-bubble / hold control driven by the FSM.

Test Plan:
- ALU op (RegWriteM=1, ALUOutM=0x0000_0010, WriteRegM=5) -> StallM never asserted. Next edge: RegWriteW=1, ALUOutW=0x10, WriteRegW=5, dmem_req=0 throughout.
- Load at 0x100, memory returns ready after 3 wait cycles with rdata=0xDEAD_BEEF:
  - dmem_req high for 4 cycles with addr=0x100 and we=0.
  - StallM high for 4 cycles.
  - Completion edge: ReadDataW=0xDEADBEEF, MemtoRegW=1.
- Store to 0x204 with WriteDataM=0x1234_5678 and zero-wait ready -> dmem_we=1, wdata=0x12345678 for exactly 1 cycle, StallM high for 1 cycle, ReadDataW unchanged.
- Load at 0x102 (misaligned) -> no dmem_req, StallM=0, MemFaultW=1 for one cycle, RegWriteW=0.
- TIMEOUT_CYCLES=4 with dmem_ready held at 0 -> dmem_req high for 4 cycles then drops, MemFaultW pulses once, RegWriteW=0, FSM returns to IDLE.
- RST_N pulled low in the 2nd BUSY cycle -> dmem_req=0 and all W outputs=0 immediately. After release, a non-memory instruction completes normally with no stall.
